// File: rtl/vga_capture.sv
// Receive side of the VGA path: registers the timing/pixel bundle, measures line and
// frame periods, locks to them and emits active-area pixels with their coordinates.
module vga_capture #(
    parameter int CNT_W = 10,
    parameter int ERR_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_VGA_HS,
    input  logic             i_VGA_VS,
    input  logic             i_VGA_blank,
    input  logic [7:0]       i_VGA_R,
    input  logic [7:0]       i_VGA_G,
    input  logic [7:0]       i_VGA_B,
    output logic             o_pix_valid,
    output logic [7:0]       o_pix_R,
    output logic [7:0]       o_pix_G,
    output logic [7:0]       o_pix_B,
    output logic [CNT_W-1:0] o_x,
    output logic [CNT_W-1:0] o_y,
    output logic             o_sof,
    output logic             o_locked,
    output logic [CNT_W-1:0] o_h_total,
    output logic [CNT_W-1:0] o_v_total,
    output logic [ERR_W-1:0] o_err_cnt
);

    typedef enum logic [1:0] {
        S_SEARCH  = 2'd0,
        S_MEASURE = 2'd1,
        S_LOCKED  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [ERR_W-1:0] ERR_MAX = '1;
    localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Stage 1 input registers and the edge-history copy of the sync/blank bits
    logic       hs1_q, vs1_q, bl1_q;
    logic       hs2_q, vs2_q, bl2_q;
    logic [7:0] r1_q, g1_q, b1_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            hs1_q <= 1'b1;
            vs1_q <= 1'b1;
            bl1_q <= 1'b1;
            hs2_q <= 1'b1;
            vs2_q <= 1'b1;
            bl2_q <= 1'b1;
            r1_q  <= 8'd0;
            g1_q  <= 8'd0;
            b1_q  <= 8'd0;
        end else begin
            hs1_q <= i_VGA_HS;
            vs1_q <= i_VGA_VS;
            bl1_q <= i_VGA_blank;
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
            bl2_q <= bl1_q;
            r1_q  <= i_VGA_R;
            g1_q  <= i_VGA_G;
            b1_q  <= i_VGA_B;
        end
    end

    logic hs_fall, vs_fall, bl_fall;
    assign hs_fall = hs2_q & ~hs1_q;
    assign vs_fall = vs2_q & ~vs1_q;
    assign bl_fall = bl2_q & ~bl1_q;

    state_t           state_q;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
    logic [CNT_W-1:0] l_cnt_q, l_cnt_d;
    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;
    logic [CNT_W-1:0] line_per, frame_per;
    logic             h_sat;

    assign h_sat    = (h_cnt_q == CNT_MAX);
    assign line_per = sat_inc(h_cnt_q);
    // A coincident HS edge closes the old frame, so it is counted into this period
    assign frame_per = hs_fall ? sat_inc(l_cnt_q) : l_cnt_q;

    always_comb begin
        h_cnt_d = sat_inc(h_cnt_q);
        if (hs_fall || (state_q == S_SEARCH && vs_fall))
            h_cnt_d = '0;

        l_cnt_d = l_cnt_q;
        if (vs_fall)
            l_cnt_d = '0;
        else if (hs_fall)
            l_cnt_d = sat_inc(l_cnt_q);

        x_d = bl1_q ? sat_inc(x_q) : '0;

        y_d = y_q;
        if (vs_fall)
            y_d = '0;
        else if (bl_fall)
            y_d = sat_inc(y_q);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            h_cnt_q <= '0;
            l_cnt_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            l_cnt_q <= l_cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    // Timing FSM; the lock flag and the measured totals are registered alongside the state
    logic             locked_q;
    logic             have_prev_q;
    logic [CNT_W-1:0] h_total_q, v_total_q;
    logic [ERR_W-1:0] err_cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q     <= S_SEARCH;
            locked_q    <= 1'b0;
            have_prev_q <= 1'b0;
            h_total_q   <= '0;
            v_total_q   <= '0;
            err_cnt_q   <= '0;
        end else begin
            case (state_q)
                S_SEARCH: begin
                    if (vs_fall) begin
                        state_q     <= S_MEASURE;
                        have_prev_q <= 1'b0;
                    end
                end
                S_MEASURE: begin
                    if (hs_fall) begin
                        h_total_q   <= line_per;
                        have_prev_q <= 1'b1;
                    end
                    if (h_sat || (hs_fall && have_prev_q && line_per != h_total_q)) begin
                        state_q <= S_SEARCH;
                    end else if (vs_fall) begin
                        v_total_q <= frame_per;
                        state_q   <= S_LOCKED;
                        locked_q  <= 1'b1;
                    end
                end
                S_LOCKED: begin
                    if (h_sat ||
                        (hs_fall && line_per != h_total_q) ||
                        (vs_fall && frame_per != v_total_q)) begin
                        state_q  <= S_SEARCH;
                        locked_q <= 1'b0;
                        if (err_cnt_q != ERR_MAX)
                            err_cnt_q <= err_cnt_q + ERR_ONE;
                    end
                end
                default: begin
                    state_q  <= S_SEARCH;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    // Stage 2 output registers
    logic             valid_q, sof_q;
    logic [7:0]       r2_q, g2_q, b2_q;
    logic [CNT_W-1:0] ox_q, oy_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            valid_q <= 1'b0;
            sof_q   <= 1'b0;
            r2_q    <= 8'd0;
            g2_q    <= 8'd0;
            b2_q    <= 8'd0;
            ox_q    <= '0;
            oy_q    <= '0;
        end else begin
            valid_q <= bl1_q && (state_q == S_LOCKED);
            sof_q   <= vs_fall && (state_q == S_LOCKED);
            r2_q    <= r1_q;
            g2_q    <= g1_q;
            b2_q    <= b1_q;
            ox_q    <= bl1_q ? x_q : '0;
            oy_q    <= y_q;
        end
    end

    assign o_pix_valid = valid_q;
    assign o_pix_R     = r2_q;
    assign o_pix_G     = g2_q;
    assign o_pix_B     = b2_q;
    assign o_x         = ox_q;
    assign o_y         = oy_q;
    assign o_sof       = sof_q;
    assign o_locked    = locked_q;
    assign o_h_total   = h_total_q;
    assign o_v_total   = v_total_q;
    assign o_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_vga_capture.sv
// Directed bench for vga_capture using a scaled-down VGA raster (40-clock lines,
// 12-line frames, 24x8 active) so that many frames fit in a short run.
module tb_vga_capture;

    localparam int CNT_W  = 10;
    localparam int ERR_W  = 8;
    localparam int H_LEN  = 40;
    localparam int HS_W   = 6;
    localparam int H_ACT0 = 10;
    localparam int H_ACT  = 24;
    localparam int V_LEN  = 12;
    localparam int VS_W   = 2;
    localparam int V_ACT0 = 3;
    localparam int V_ACT  = 8;
    localparam logic [CNT_W-1:0] EXP_H = CNT_W'(H_LEN);
    localparam logic [CNT_W-1:0] EXP_V = CNT_W'(V_LEN);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             hs = 1'b1, vs = 1'b1, bl = 1'b0;
    logic [7:0]       r = 8'd0, g = 8'd0, b = 8'd0;
    logic             o_pix_valid, o_sof, o_locked;
    logic [7:0]       o_pix_R, o_pix_G, o_pix_B;
    logic [CNT_W-1:0] o_x, o_y, o_h_total, o_v_total;
    logic [ERR_W-1:0] o_err_cnt;

    vga_capture #(.CNT_W(CNT_W), .ERR_W(ERR_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_VGA_HS(hs), .i_VGA_VS(vs), .i_VGA_blank(bl),
        .i_VGA_R(r), .i_VGA_G(g), .i_VGA_B(b),
        .o_pix_valid(o_pix_valid), .o_pix_R(o_pix_R), .o_pix_G(o_pix_G), .o_pix_B(o_pix_B),
        .o_x(o_x), .o_y(o_y), .o_sof(o_sof), .o_locked(o_locked),
        .o_h_total(o_h_total), .o_v_total(o_v_total), .o_err_cnt(o_err_cnt)
    );

    always #20 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int vsf_cyc = 0;
    int hsf_at [V_LEN];

    always @(posedge clk) cyc = cyc + 1;

    // Observation side: event times and running counts, sampled 1 time unit after the edge
    int          valid_cnt = 0, blank_valid = 0, pix_bad = 0, first_cnt = 0;
    int          sof_cnt = 0, last_sof_cyc = -1, lock_rise_cyc = -1, lock_fall_cyc = -1;
    int          last_x = -1, last_y = -1;
    logic [23:0] first_rgb = 24'd0;
    logic [23:0] rgb_p1 = 24'd0, rgb_p2 = 24'd0;
    logic        bl_p1 = 1'b0, bl_p2 = 1'b0, prev_locked = 1'b0;

    always @(posedge clk) begin
        bl_p2  = bl_p1;
        bl_p1  = bl;
        rgb_p2 = rgb_p1;
        rgb_p1 = {r, g, b};
        #1;
        if (o_pix_valid) begin
            valid_cnt++;
            if (!bl_p2) blank_valid++;
            if ({o_pix_R, o_pix_G, o_pix_B} !== rgb_p2 || o_x[7:0] !== rgb_p2[23:16] ||
                o_y[7:0] !== rgb_p2[15:8])
                pix_bad++;
            if (o_x == '0 && o_y == '0) begin
                first_cnt++;
                first_rgb = {o_pix_R, o_pix_G, o_pix_B};
            end
            last_x = int'(o_x);
            last_y = int'(o_y);
        end
        if (o_sof) begin
            sof_cnt++;
            last_sof_cyc = cyc;
        end
        if (o_locked && !prev_locked) lock_rise_cyc = cyc;
        if (!o_locked && prev_locked) lock_fall_cyc = cyc;
        prev_locked = o_locked;
    end

    task automatic drive(input logic h, input logic v, input logic a,
                         input logic [7:0] rr, input logic [7:0] gg);
        @(negedge clk);
        hs = h;
        vs = v;
        bl = a;
        r  = rr;
        g  = gg;
        b  = a ? 8'hA5 : 8'h00;
    endtask

    task automatic gen_line(input int vpos, input int h0, input int len);
        logic act;
        for (int h = h0; h < len; h++) begin
            act = (vpos >= V_ACT0) && (vpos < V_ACT0 + V_ACT) && (h >= H_ACT0) && (h < H_ACT0 + H_ACT);
            drive(h >= HS_W, vpos >= VS_W, act,
                  act ? 8'(h - H_ACT0) : 8'd0, act ? 8'(vpos - V_ACT0) : 8'd0);
            if (h == 0) hsf_at[vpos] = cyc;
            if (h == 0 && vpos == 0) vsf_cyc = cyc;
        end
    endtask

    task automatic gen_frame(input int nlines, input int short_line);
        for (int v = 0; v < nlines; v++)
            gen_line(v, 0, (v == short_line) ? H_LEN - 1 : H_LEN);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) drive(1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
        tests++; if (o_locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %0b want 0", o_locked); end
        tests++; if (o_pix_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", o_pix_valid); end
        tests++; if (o_sof !== 1'b0) begin fails++; $display("FAIL reset_sof: got %0b want 0", o_sof); end
        tests++; if (o_h_total !== '0 || o_v_total !== '0) begin fails++; $display("FAIL reset_totals: got %0d/%0d want 0/0", o_h_total, o_v_total); end
        tests++; if (o_err_cnt !== '0) begin fails++; $display("FAIL reset_err: got %0d want 0", o_err_cnt); end
        tests++; if (o_x !== '0 || o_y !== '0) begin fails++; $display("FAIL reset_xy: got %0d,%0d want 0,0", o_x, o_y); end
        tests++; if ({o_pix_R, o_pix_G, o_pix_B} !== 24'd0) begin fails++; $display("FAIL reset_rgb: got %h want 0", {o_pix_R, o_pix_G, o_pix_B}); end
        rst_n = 1'b1;
        repeat (8) drive(1'b1, 1'b1, 1'b0, 8'd0, 8'd0);
        tests++; if (o_locked !== 1'b0 || sof_cnt != 0 || valid_cnt != 0) begin fails++; $display("FAIL reset_idle: got locked=%0b sof=%0d valid=%0d want 0/0/0", o_locked, sof_cnt, valid_cnt); end
    endtask

    task automatic test_nominal();
        int sof0;
        sof0 = sof_cnt;
        gen_frame(V_LEN, -1);
        tests++; if (o_locked !== 1'b0) begin fails++; $display("FAIL nominal_measuring: got %0b want 0", o_locked); end
        gen_frame(V_LEN, -1);
        tests++; if (lock_rise_cyc != vsf_cyc + 2) begin fails++; $display("FAIL nominal_lock_time: got %0d want %0d", lock_rise_cyc, vsf_cyc + 2); end
        tests++; if (o_h_total !== EXP_H || o_v_total !== EXP_V) begin fails++; $display("FAIL nominal_totals: got %0d/%0d want %0d/%0d", o_h_total, o_v_total, H_LEN, V_LEN); end
        tests++; if (sof_cnt != sof0) begin fails++; $display("FAIL nominal_no_sof_at_lock: got %0d want %0d", sof_cnt, sof0); end
        gen_frame(V_LEN, -1);
        tests++; if (sof_cnt != sof0 + 1) begin fails++; $display("FAIL nominal_sof_count: got %0d want %0d", sof_cnt, sof0 + 1); end
        tests++; if (last_sof_cyc != vsf_cyc + 2) begin fails++; $display("FAIL nominal_sof_time: got %0d want %0d", last_sof_cyc, vsf_cyc + 2); end
        tests++; if (o_err_cnt !== '0 || o_locked !== 1'b1) begin fails++; $display("FAIL nominal_state: got err=%0d locked=%0b want 0/1", o_err_cnt, o_locked); end
    endtask

    task automatic test_pixel_map();
        int v0, bv0, pb0, f0;
        v0 = valid_cnt; bv0 = blank_valid; pb0 = pix_bad; f0 = first_cnt;
        gen_frame(V_LEN, -1);
        tests++; if (valid_cnt - v0 != H_ACT * V_ACT) begin fails++; $display("FAIL pix_valid_count: got %0d want %0d", valid_cnt - v0, H_ACT * V_ACT); end
        tests++; if (blank_valid != bv0) begin fails++; $display("FAIL pix_valid_in_blank: got %0d want %0d", blank_valid, bv0); end
        tests++; if (pix_bad != pb0) begin fails++; $display("FAIL pix_data: got %0d bad want %0d", pix_bad - pb0, 0); end
        tests++; if (first_cnt != f0 + 1 || first_rgb !== 24'h0000A5) begin fails++; $display("FAIL pix_origin: got n=%0d rgb=%h want n=1 rgb=0000a5", first_cnt - f0, first_rgb); end
        tests++; if (last_x != H_ACT - 1 || last_y != V_ACT - 1) begin fails++; $display("FAIL pix_last: got %0d,%0d want %0d,%0d", last_x, last_y, H_ACT - 1, V_ACT - 1); end
    endtask

    task automatic test_line_glitch();
        gen_frame(V_LEN, 5);
        tests++; if (lock_fall_cyc != hsf_at[6] + 2) begin fails++; $display("FAIL glitch_unlock_time: got %0d want %0d", lock_fall_cyc, hsf_at[6] + 2); end
        tests++; if (o_err_cnt !== 8'd1 || o_locked !== 1'b0) begin fails++; $display("FAIL glitch_err: got err=%0d locked=%0b want 1/0", o_err_cnt, o_locked); end
        gen_frame(V_LEN, -1);
        tests++; if (o_locked !== 1'b0) begin fails++; $display("FAIL glitch_early_lock: got %0b want 0", o_locked); end
        gen_frame(V_LEN, -1);
        tests++; if (o_locked !== 1'b1 || lock_rise_cyc != vsf_cyc + 2) begin fails++; $display("FAIL glitch_relock: got locked=%0b at %0d want 1 at %0d", o_locked, lock_rise_cyc, vsf_cyc + 2); end
        tests++; if (o_h_total !== EXP_H) begin fails++; $display("FAIL glitch_h_total: got %0d want %0d", o_h_total, H_LEN); end
    endtask

    task automatic test_frame_mismatch();
        gen_frame(V_LEN - 1, -1);
        tests++; if (o_locked !== 1'b1) begin fails++; $display("FAIL frame_short_lines_ok: got %0b want 1", o_locked); end
        gen_frame(V_LEN, -1);
        tests++; if (lock_fall_cyc != vsf_cyc + 2) begin fails++; $display("FAIL frame_unlock_time: got %0d want %0d", lock_fall_cyc, vsf_cyc + 2); end
        tests++; if (o_err_cnt !== 8'd2) begin fails++; $display("FAIL frame_err: got %0d want 2", o_err_cnt); end
        tests++; if (o_v_total !== EXP_V) begin fails++; $display("FAIL frame_v_total: got %0d want %0d", o_v_total, V_LEN); end
        gen_frame(V_LEN, -1);
        gen_frame(V_LEN, -1);
        tests++; if (o_locked !== 1'b1 || lock_rise_cyc != vsf_cyc + 2) begin fails++; $display("FAIL frame_relock: got locked=%0b at %0d want 1 at %0d", o_locked, lock_rise_cyc, vsf_cyc + 2); end
    endtask

    task automatic test_stuck();
        gen_frame(V_LEN, -1);
        repeat (1100) drive(1'b1, 1'b1, 1'b1, 8'd0, 8'd0);
        // h_cnt restarts two edges after the last HS fall and saturates 1023 cycles later
        tests++; if (lock_fall_cyc != hsf_at[V_LEN - 1] + 1026) begin fails++; $display("FAIL stuck_unlock_time: got %0d want %0d", lock_fall_cyc, hsf_at[V_LEN - 1] + 1026); end
        tests++; if (o_err_cnt !== 8'd3) begin fails++; $display("FAIL stuck_err: got %0d want 3", o_err_cnt); end
        repeat (200) drive(1'b1, 1'b1, 1'b1, 8'd0, 8'd0);
        tests++; if (o_err_cnt !== 8'd3 || o_locked !== 1'b0) begin fails++; $display("FAIL stuck_err_once: got err=%0d locked=%0b want 3/0", o_err_cnt, o_locked); end
    endtask

    task automatic test_reset_mid_frame();
        int v0;
        gen_frame(V_LEN, -1);
        gen_frame(V_LEN, -1);
        tests++; if (o_locked !== 1'b1) begin fails++; $display("FAIL midrst_prelock: got %0b want 1", o_locked); end
        for (int v = 0; v < 6; v++) gen_line(v, 0, H_LEN);
        gen_line(6, 0, 1);
        rst_n = 1'b0;
        gen_line(6, 1, 2);
        tests++; if (o_locked !== 1'b0 || o_err_cnt !== '0 || o_h_total !== '0 || o_v_total !== '0) begin fails++; $display("FAIL midrst_regs: got locked=%0b err=%0d h=%0d v=%0d want all 0", o_locked, o_err_cnt, o_h_total, o_v_total); end
        tests++; if (o_pix_valid !== 1'b0 || o_sof !== 1'b0 || o_x !== '0 || o_y !== '0 || {o_pix_R, o_pix_G, o_pix_B} !== 24'd0) begin fails++; $display("FAIL midrst_pix: got valid=%0b sof=%0b x=%0d y=%0d rgb=%h want all 0", o_pix_valid, o_sof, o_x, o_y, {o_pix_R, o_pix_G, o_pix_B}); end
        gen_line(6, 2, 3);
        gen_line(6, 3, 4);
        rst_n = 1'b1;
        v0 = valid_cnt;
        gen_line(6, 4, H_LEN);
        for (int v = 7; v < V_LEN; v++) gen_line(v, 0, H_LEN);
        gen_frame(V_LEN, -1);
        tests++; if (valid_cnt != v0 || o_locked !== 1'b0) begin fails++; $display("FAIL midrst_unlocked_blank: got valid=%0d locked=%0b want 0/0", valid_cnt - v0, o_locked); end
        gen_frame(V_LEN, -1);
        tests++; if (o_locked !== 1'b1 || lock_rise_cyc != vsf_cyc + 2) begin fails++; $display("FAIL midrst_relock: got locked=%0b at %0d want 1 at %0d", o_locked, lock_rise_cyc, vsf_cyc + 2); end
        tests++; if (o_err_cnt !== '0) begin fails++; $display("FAIL midrst_err: got %0d want 0", o_err_cnt); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_pixel_map();
        test_line_glitch();
        test_frame_mismatch();
        test_stuck();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
